// File: rtl/rcv_timer_pkg.sv
// Shared types and default constants for the serial receive timing controller.
package rcv_timer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHalf,
        StBits,
        StDone
    } state_e;

    localparam int unsigned DefClksPerBit = 10;
    localparam int unsigned DefDataBits   = 8;

    // bit_idx must hold DATA_BITS+1, the strobe count after the stop bit.
    function automatic int unsigned idx_width(input int unsigned data_bits);
        return $clog2(data_bits + 2);
    endfunction

endpackage

// File: rtl/rcv_timer_ctrl_if.sv
// Control/status bundle between the receive timing controller and its user.
// Defining RCV_TIMER_FRAMING_ERR_EN adds stop_bit_val and framing_error.
interface rcv_timer_ctrl_if #(
    parameter int unsigned DATA_BITS = rcv_timer_pkg::DefDataBits
);
    import rcv_timer_pkg::*;

    localparam int unsigned IdxW = idx_width(DATA_BITS);

    logic            start;
    logic            abort;
    logic            shift_strobe;
    logic [IdxW-1:0] bit_idx;
    logic            busy;
    logic            packet_done;
`ifdef RCV_TIMER_FRAMING_ERR_EN
    logic            stop_bit_val;
    logic            framing_error;

    modport master (
        output start, abort, stop_bit_val,
        input  shift_strobe, bit_idx, busy, packet_done, framing_error
    );
    modport slave (
        input  start, abort, stop_bit_val,
        output shift_strobe, bit_idx, busy, packet_done, framing_error
    );
`else
    modport master (
        output start, abort,
        input  shift_strobe, bit_idx, busy, packet_done
    );
    modport slave (
        input  start, abort,
        output shift_strobe, bit_idx, busy, packet_done
    );
`endif

endinterface

// File: rtl/tick_counter.sv
// Clearable up-counter that pulses tick_o in the enabled cycle where the count
// equals term_i.
module tick_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic [Width-1:0] count_o,
    output logic             tick_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tick_o  = en_i && (count_q == term_i);

endmodule

// File: rtl/rcv_timer_ctrl.sv
// Packet timing controller for a serial receiver: half-bit alignment, then one
// sample strobe per bit period. Optional RCV_TIMER_FRAMING_ERR_EN adds a stop-bit check.
module rcv_timer_ctrl
    import rcv_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned DATA_BITS    = DefDataBits
) (
    input logic             clk,
    input logic             n_rst,
    rcv_timer_ctrl_if.slave bus
);

    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned     IdxW     = idx_width(DATA_BITS);
    localparam logic [CntW-1:0] HalfTerm = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitTerm  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DATA_BITS);

    state_e          state_d, state_q;
    logic            strobe_d, strobe_q;
    logic            period_en, period_clr, period_tick;
    logic [CntW-1:0] period_term;
    logic [CntW-1:0] unused_period_cnt;
    logic            bit_clr, bit_tick;
    logic [IdxW-1:0] bit_cnt;

    // The period counter restarts on its own tick, so HALF and each bit period
    // all begin from zero.
    assign period_en   = (state_q == StHalf) || (state_q == StBits);
    assign period_term = (state_q == StHalf) ? HalfTerm : BitTerm;
    assign period_clr  = bus.abort || !period_en || period_tick;
    assign bit_clr     = bus.abort || (state_q == StIdle) || (state_q == StDone);

    tick_counter #(
        .Width (CntW)
    ) u_period_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (period_clr),
        .en_i    (period_en),
        .term_i  (period_term),
        .count_o (unused_period_cnt),
        .tick_o  (period_tick)
    );

    // Counts issued strobes; its tick marks the stop-bit strobe cycle.
    tick_counter #(
        .Width (IdxW)
    ) u_bit_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (bit_clr),
        .en_i    (strobe_q),
        .term_i  (LastIdx),
        .count_o (bit_cnt),
        .tick_o  (bit_tick)
    );

    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.start) state_d = StHalf;
                StHalf:  if (period_tick) state_d = StBits;
                StBits: begin
                    strobe_d = period_tick;
                    if (bit_tick) state_d = StDone;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.shift_strobe = strobe_q;
    assign bus.bit_idx      = bit_cnt;
    assign bus.busy         = (state_q != StIdle);
    assign bus.packet_done  = (state_q == StDone);

`ifdef RCV_TIMER_FRAMING_ERR_EN
    logic fe_d, fe_q;

    // Sticky until the next accepted start or an abort.
    always_comb begin
        fe_d = fe_q;
        if (bus.abort || ((state_q == StIdle) && bus.start)) begin
            fe_d = 1'b0;
        end else if (bit_tick && !bus.stop_bit_val) begin
            fe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fe_q <= 1'b0;
        end else begin
            fe_q <= fe_d;
        end
    end

    assign bus.framing_error = fe_q;
`endif

endmodule

// File: tb/tb_rcv_timer_ctrl.sv
// Randomised scoreboard bench: two controllers (10 clk/bit x 8 bits, 3 clk/bit x 1 bit)
// share stimulus and are checked against an arithmetic packet-timing model.
module tb_rcv_timer_ctrl;

    localparam int CpbA = 10;
    localparam int DbA  = 8;
    localparam int CpbB = 3;
    localparam int DbB  = 1;

    typedef struct {
        int cyc;
        int done;
        int idx;
    } ev_t;

    typedef struct {
        int stb;
        int dn;
        int bsy;
        int idx;
        int fe;
    } obs_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
`ifdef RCV_TIMER_FRAMING_ERR_EN
    logic stop_bit_val = 1'b1;
    int   m_fe [2];
`endif

    int  cyc      = 0;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  m_act [2];
    int  m_t0  [2];
    ev_t sb_q  [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rcv_timer_ctrl_if #(.DATA_BITS(DbA)) ifa ();
    rcv_timer_ctrl_if #(.DATA_BITS(DbB)) ifb ();

    assign ifa.start = start;
    assign ifa.abort = abort;
    assign ifb.start = start;
    assign ifb.abort = abort;
`ifdef RCV_TIMER_FRAMING_ERR_EN
    assign ifa.stop_bit_val = stop_bit_val;
    assign ifb.stop_bit_val = stop_bit_val;
`endif

    rcv_timer_ctrl #(.CLKS_PER_BIT(CpbA), .DATA_BITS(DbA)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifa)
    );

    rcv_timer_ctrl #(.CLKS_PER_BIT(CpbB), .DATA_BITS(DbB)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (ifb)
    );

    function automatic int cpb(input int i);
        return (i == 0) ? CpbA : CpbB;
    endfunction

    function automatic int db(input int i);
        return (i == 0) ? DbA : DbB;
    endfunction

    function automatic int hw(input int i);
        return cpb(i) / 2;
    endfunction

    // Cycle in which packet_done is expected for the packet launched at m_t0.
    function automatic int t_done(input int i);
        return m_t0[i] + hw(i) + (db(i) + 1) * cpb(i) + 1;
    endfunction

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic obs_t observe(input int i);
        obs_t o;
        o.fe = 0;
        if (i == 0) begin
            o.stb = int'(ifa.shift_strobe);
            o.dn  = int'(ifa.packet_done);
            o.bsy = int'(ifa.busy);
            o.idx = int'(ifa.bit_idx);
`ifdef RCV_TIMER_FRAMING_ERR_EN
            o.fe  = int'(ifa.framing_error);
`endif
        end else begin
            o.stb = int'(ifb.shift_strobe);
            o.dn  = int'(ifb.packet_done);
            o.bsy = int'(ifb.busy);
            o.idx = int'(ifb.bit_idx);
`ifdef RCV_TIMER_FRAMING_ERR_EN
            o.fe  = int'(ifb.framing_error);
`endif
        end
        return o;
    endfunction

    // Model update for the edge that ends cycle c (inputs st/ab sampled there).
    function automatic void model_edge(input int i, input int c, input int st, input int ab);
        if (ab != 0) begin
            while (sb_q[i].size() > 0 && sb_q[i][$].cyc > c) void'(sb_q[i].pop_back());
            m_act[i] = 0;
`ifdef RCV_TIMER_FRAMING_ERR_EN
            m_fe[i] = 0;
`endif
        end else if (st != 0 && (m_act[i] == 0 || c > t_done(i))) begin
            m_act[i] = 1;
            m_t0[i]  = c + 1;
`ifdef RCV_TIMER_FRAMING_ERR_EN
            m_fe[i] = 0;
`endif
            for (int k = 1; k <= db(i) + 1; k++) begin
                sb_q[i].push_back(ev_t'{cyc: m_t0[i] + hw(i) + k * cpb(i), done: 0, idx: k - 1});
            end
            sb_q[i].push_back(ev_t'{cyc: t_done(i), done: 1, idx: db(i) + 1});
        end
`ifdef RCV_TIMER_FRAMING_ERR_EN
        else if (m_act[i] != 0 && c == t_done(i) - 1 && stop_bit_val == 1'b0) begin
            m_fe[i] = 1;
        end
`endif
    endfunction

    task automatic step(input int st, input int ab);
        @(negedge clk);
        start = st[0];
        abort = ab[0];
`ifdef RCV_TIMER_FRAMING_ERR_EN
        stop_bit_val = 1'($urandom_range(0, 1));
`endif
        for (int i = 0; i < 2; i++) model_edge(i, cyc, st, ab);
    endtask

    task automatic check_all_zero(input string tag);
        obs_t o;
        for (int i = 0; i < 2; i++) begin
            o = observe(i);
            check($sformatf("%s dut%0d shift_strobe", tag, i), o.stb, 0);
            check($sformatf("%s dut%0d packet_done", tag, i), o.dn, 0);
            check($sformatf("%s dut%0d busy", tag, i), o.bsy, 0);
            check($sformatf("%s dut%0d bit_idx", tag, i), o.idx, 0);
`ifdef RCV_TIMER_FRAMING_ERR_EN
            check($sformatf("%s dut%0d framing_error", tag, i), o.fe, 0);
`endif
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        for (int i = 0; i < 2; i++) begin
            sb_q[i].delete();
            m_act[i] = 0;
`ifdef RCV_TIMER_FRAMING_ERR_EN
            m_fe[i] = 0;
`endif
        end
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic monitor_dut(input int i);
        obs_t o;
        ev_t  e;
        int   exp_busy;
        int   exp_idx;
        o = observe(i);
        while (sb_q[i].size() > 0 && sb_q[i][0].cyc < cyc) begin
            e = sb_q[i].pop_front();
            check($sformatf("dut%0d missed event, now vs due", i), cyc, e.cyc);
        end
        if (o.stb != 0 || o.dn != 0) begin
            if (sb_q[i].size() == 0) begin
                check($sformatf("dut%0d unexpected strobe|done", i), o.stb + o.dn, 0);
            end else begin
                e = sb_q[i].pop_front();
                check($sformatf("dut%0d event cycle", i), cyc, e.cyc);
                check($sformatf("dut%0d packet_done", i), o.dn, e.done);
                check($sformatf("dut%0d shift_strobe", i), o.stb, 1 - e.done);
                check($sformatf("dut%0d bit_idx at event", i), o.idx, e.idx);
            end
        end
        exp_busy = (m_act[i] != 0 && cyc <= t_done(i)) ? 1 : 0;
        exp_idx  = 0;
        if (exp_busy != 0 && cyc > m_t0[i] + hw(i)) begin
            exp_idx = (cyc - 1 - m_t0[i] - hw(i)) / cpb(i);
            if (exp_idx > db(i) + 1) exp_idx = db(i) + 1;
        end
        check($sformatf("dut%0d busy", i), o.bsy, exp_busy);
        check($sformatf("dut%0d bit_idx", i), o.idx, exp_idx);
`ifdef RCV_TIMER_FRAMING_ERR_EN
        check($sformatf("dut%0d framing_error", i), o.fe, m_fe[i]);
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (n_rst) begin
                for (int i = 0; i < 2; i++) monitor_dut(i);
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0;
            m_t0[i]  = 0;
`ifdef RCV_TIMER_FRAMING_ERR_EN
            m_fe[i] = 0;
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) step(0, 0);

        // Single packet, run to completion.
        step(1, 0);
        repeat (110) step(0, 0);

        // Abort during cycle 40 of a packet.
        step(1, 0);
        repeat (40) step(0, 0);
        step(0, 1);
        repeat (20) step(0, 0);

        // Start and abort together while idle.
        step(1, 1);
        repeat (5) step(0, 0);

        // Asynchronous reset mid-packet, then a fresh packet.
        step(1, 0);
        repeat (30) step(0, 0);
        pulse_reset();
        step(1, 0);
        repeat (110) step(0, 0);

        // Start held high: back-to-back packets with one idle cycle between.
        repeat (250) step(1, 0);

        // Random start/abort traffic.
        repeat (3000) begin
            step(($urandom_range(0, 7) == 0) ? 1 : 0, ($urandom_range(0, 63) == 0) ? 1 : 0);
        end
        repeat (120) step(0, 0);

        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d pending events at end", i), sb_q[i].size(), 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
